// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: multicycle OTTER control FSM sequencing fetch/exec/writeback/interrupt and counting retired instructions
module otter_cu_fsm (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNC3,
  input  logic        INTR,
  output logic        RST_OUT,
  output logic        PC_WE,
  output logic        REG_WE,
  output logic        MEM_RDEN1,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic        CSR_WE,
  output logic        INT_TAKEN,
  output logic        ILLEGAL,
  output logic [31:0] INSTRET
);
  typedef enum logic [2:0] {INIT, FETCH, EXEC, WB, INTRPT} state_t;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111,
                         BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011,
                         OP_IMM = 7'b0010011, OP = 7'b0110011, SYSTEM = 7'b1110011;
  state_t state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic is_load, is_sys, csr_op, reg_op, legal, exec;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= INIT;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end
  always_comb begin
    is_load   = OPCODE == LOAD;
    state_d   = state_q == INIT  ? FETCH :
                state_q == FETCH ? EXEC :
                state_q == EXEC  ? (is_load ? WB : INTR ? INTRPT : FETCH) :
                state_q == WB    ? (INTR ? INTRPT : FETCH) :
                state_q == INTRPT ? FETCH : INIT;
    instret_d = instret_q + {31'd0, (state_q == EXEC && !is_load) || state_q == WB};
  end
  always_comb begin
    exec      = state_q == EXEC;
    is_sys    = OPCODE == SYSTEM;
    csr_op    = is_sys && FUNC3 != 3'b000;
    reg_op    = OPCODE == LUI || OPCODE == AUIPC || OPCODE == JAL || OPCODE == JALR ||
                OPCODE == OP_IMM || OPCODE == OP || csr_op;
    legal     = reg_op || is_sys || OPCODE == BRANCH || OPCODE == LOAD || OPCODE == STORE;
    RST_OUT   = state_q == INIT;
    MEM_RDEN1 = state_q == FETCH;
    MEM_RDEN2 = exec && is_load;
    MEM_WE2   = exec && OPCODE == STORE;
    CSR_WE    = exec && csr_op;
    REG_WE    = (exec && reg_op) || state_q == WB;
    PC_WE     = (exec && !is_load) || state_q == WB || state_q == INTRPT;
    INT_TAKEN = state_q == INTRPT;
    ILLEGAL   = exec && !legal;
    INSTRET   = instret_q;
  end
endmodule

// File: tb/tb_otter_cu_fsm.sv
// tb_otter_cu_fsm: directed and random checks of otter_cu_fsm against an instruction-level reference model
module tb_otter_cu_fsm;
  logic CLK, RST_N, INTR;
  logic [6:0] OPCODE;
  logic [2:0] FUNC3;
  logic RST_OUT, PC_WE, REG_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN, ILLEGAL;
  logic [31:0] INSTRET;
  int n_assert = 0, n_fail = 0;
  logic [31:0] model_ret;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111,
                         BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011,
                         OP_IMM = 7'b0010011, OP = 7'b0110011, SYSTEM = 7'b1110011;
  localparam logic [8:0] V_INIT = 9'b1_0000_0000, V_FETCH = 9'b0_0010_0000,
                         V_WB = 9'b0_1100_0000, V_INT = 9'b0_1000_0010;
  logic [6:0] ops [10] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM};
  otter_cu_fsm dut (
    .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .FUNC3(FUNC3), .INTR(INTR),
    .RST_OUT(RST_OUT), .PC_WE(PC_WE), .REG_WE(REG_WE), .MEM_RDEN1(MEM_RDEN1),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .CSR_WE(CSR_WE), .INT_TAKEN(INT_TAKEN),
    .ILLEGAL(ILLEGAL), .INSTRET(INSTRET)
  );
  initial CLK = 0;
  always #5 CLK = ~CLK;
  function automatic logic [8:0] outs();
    return {RST_OUT, PC_WE, REG_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN, ILLEGAL};
  endfunction
  function automatic logic [8:0] exec_exp(logic [6:0] op, logic [2:0] f3);
    logic legal, wr, csr;
    legal = op inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM};
    if (op == LOAD) return 9'b0_0001_0000;
    csr = op == SYSTEM && f3 != 3'b000;
    wr  = (op inside {LUI, AUIPC, JAL, JALR, OP_IMM, OP}) || csr;
    return {1'b0, 1'b1, wr, 2'b00, op == STORE, csr, 1'b0, !legal};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic do_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                          input logic intr_f, input logic intr_e, input logic intr_w);
    logic last;
    cyc(); OPCODE = 7'($urandom); FUNC3 = 3'($urandom); INTR = intr_f; #1;
    chk({nm, "_fetch"}, 32'(outs()), 32'(V_FETCH));
    chk({nm, "_ret_fetch"}, INSTRET, model_ret);
    cyc(); OPCODE = op; FUNC3 = f3; INTR = intr_e; #1;
    chk({nm, "_exec"}, 32'(outs()), 32'(exec_exp(op, f3)));
    chk({nm, "_ret_exec"}, INSTRET, model_ret);
    last = intr_e;
    if (op == LOAD) begin
      cyc(); OPCODE = op; FUNC3 = f3; INTR = intr_w; #1;
      chk({nm, "_wb"}, 32'(outs()), 32'(V_WB));
      chk({nm, "_ret_wb"}, INSTRET, model_ret);
      last = intr_w;
    end
    model_ret = model_ret + 32'd1;
    if (last) begin
      cyc(); OPCODE = 7'($urandom); FUNC3 = 3'($urandom); INTR = 1'($urandom); #1;
      chk({nm, "_intrpt"}, 32'(outs()), 32'(V_INT));
      chk({nm, "_ret_intrpt"}, INSTRET, model_ret);
    end
  endtask
  initial begin
    logic [6:0] op;
    int sel;
    RST_N = 0; INTR = 0; OPCODE = '0; FUNC3 = '0;
    model_ret = '0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("reset_hold", 32'(outs()), 32'(V_INIT));
      chk("reset_ret", INSTRET, 32'd0);
    end
    cyc(); RST_N = 1; #1;
    chk("reset_release_init", 32'(outs()), 32'(V_INIT));
    do_instr("addi", OP_IMM, 3'b000, 0, 0, 0);
    do_instr("lw", LOAD, 3'b010, 0, 0, 0);
    do_instr("sw", STORE, 3'b010, 0, 0, 0);
    do_instr("beq", BRANCH, 3'b000, 0, 0, 0);
    do_instr("csrrw", SYSTEM, 3'b001, 0, 0, 0);
    do_instr("illegal", 7'b0000000, 3'b000, 0, 0, 0);
    do_instr("lw_intr", LOAD, 3'b010, 1, 1, 1);
    do_instr("lw_intr_drop", LOAD, 3'b010, 1, 1, 0);
    do_instr("ecall_intr", SYSTEM, 3'b000, 0, 1, 0);
    do_instr("after_intr", OP, 3'b000, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 11);
      op = sel < 10 ? ops[sel] : 7'($urandom);
      do_instr("rnd", op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    cyc(); OPCODE = LOAD; FUNC3 = 3'b010; INTR = 0; #1;
    chk("rst_lw_fetch", 32'(outs()), 32'(V_FETCH));
    cyc(); #1;
    chk("rst_lw_exec", 32'(outs()), 32'(exec_exp(LOAD, 3'b010)));
    cyc(); RST_N = 0; INTR = 1; #1;
    chk("rst_lw_wb", 32'(outs()), 32'(V_WB));
    cyc(); #1;
    chk("rst_mid_init", 32'(outs()), 32'(V_INIT));
    chk("rst_mid_ret", INSTRET, 32'd0);
    model_ret = '0;
    cyc(); INTR = 0; #1;
    chk("rst_mid_hold", 32'(outs()), 32'(V_INIT));
    cyc(); RST_N = 1; #1;
    chk("rst_mid_release", 32'(outs()), 32'(V_INIT));
    do_instr("post_rst_lui", LUI, 3'b000, 0, 0, 0);
    cyc(); OPCODE = OP; FUNC3 = 3'b000; INTR = 0;
    force dut.instret_q = 32'hFFFF_FFFE;
    #1;
    chk("wrap_fetch", 32'(outs()), 32'(V_FETCH));
    chk("wrap_preload", INSTRET, 32'hFFFF_FFFE);
    release dut.instret_q;
    model_ret = 32'hFFFF_FFFE;
    cyc(); #1;
    chk("wrap_exec", 32'(outs()), 32'(exec_exp(OP, 3'b000)));
    model_ret = model_ret + 32'd1;
    do_instr("wrap_max", JAL, 3'b000, 0, 0, 0);
    do_instr("wrap_zero", AUIPC, 3'b000, 0, 0, 0);
    chk("wrap_final", model_ret, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/otter_cu_fsm.md
# otter_cu_fsm

Multicycle control-unit state machine for the OTTER MCU. It sequences the single-ported datapath (PC, register file, immediate generator, ALU, memory, CSR unit) through fetch, execute, load writeback and interrupt-entry cycles. It issues the per-cycle write and read enables and keeps a retired-instruction counter. Decode of ALU function and mux selects stays in the combinational decoder; this block only decides *when* things happen.

## Interface
- No parameters.
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- OPCODE  in  7  instruction bits [6:0] from instruction memory output, valid in EXEC and WB.
- FUNC3  in  3  instruction bits [14:12], valid in EXEC.
- INTR  in  1  interrupt request, already gated by MIE; level-sensitive.
- RST_OUT  out  1  datapath reset (PC to 0, register file untouched).
- PC_WE  out  1  PC write enable.
- REG_WE  out  1  register file write enable.
- MEM_RDEN1  out  1  instruction memory read enable.
- MEM_RDEN2  out  1  data memory read enable.
- MEM_WE2  out  1  data memory write enable.
- CSR_WE  out  1  CSR write enable.
- INT_TAKEN  out  1  interrupt entry strobe to CSR unit (save PC to MEPC, clear MIE).
- ILLEGAL  out  1  unrecognised opcode in EXEC.
- INSTRET  out  32  count of retired instructions.

## Operation
- States: INIT, FETCH, EXEC, WB, INTRPT. State register 3 bits, registered; enables are combinational from state plus OPCODE/FUNC3, i.e. Mealy in EXEC.
- Any output not listed as asserted in a state is 0.
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, SYSTEM 1110011. Any other opcode is illegal.
- INIT: RST_OUT=1; next FETCH.
- FETCH: MEM_RDEN1=1; next EXEC.
- EXEC, by opcode:
  - LOAD: MEM_RDEN2=1, PC_WE=0; next WB unconditionally.
  - STORE: MEM_WE2=1, PC_WE=1.
  - BRANCH: PC_WE=1.
  - LUI, AUIPC, JAL, JALR, OP_IMM, OP: REG_WE=1, PC_WE=1.
  - SYSTEM with FUNC3≠000: CSR_WE=1, REG_WE=1, PC_WE=1.
  - SYSTEM with FUNC3=000 (mret/ecall): PC_WE=1 only.
  - Illegal opcode: ILLEGAL=1, PC_WE=1, no other writes; the instruction is treated as a NOP.
- WB: REG_WE=1, PC_WE=1.
- Exit from EXEC (non-LOAD) and from WB: INTRPT if INTR=1 in that cycle, else FETCH.
- INTRPT: INT_TAKEN=1, PC_WE=1 (the PC mux selects MTVEC, driven by the decoder from INT_TAKEN); next FETCH unconditionally. INTR is not re-sampled in INTRPT.
- INSTRET:
  - Increments by 1 at the end of each EXEC (non-LOAD, illegal included) and each WB cycle.
  - Never increments in INIT, FETCH or INTRPT.
  - Wraps from 0xFFFFFFFF to 0x00000000.

## Timing
- Reset: RST_N sampled low at an edge forces state=INIT and INSTRET=0 at that edge. This holds mid-instruction; any enable in the cycle after the edge reflects INIT only.
- While RST_N is held low, state stays INIT, so RST_OUT=1 and all other enables are 0.
- First cycle after RST_N goes high: INIT (RST_OUT=1). Next cycle: FETCH.
- Instruction latency:
  - Non-load: 2 cycles (FETCH, EXEC).
  - Load: 3 cycles (FETCH, EXEC, WB).
  - An interrupt adds exactly 1 INTRPT cycle after the instruction completes.
- INSTRET new value is visible the cycle after the retiring cycle.
- INTR asserted in FETCH, or in a LOAD's EXEC, is not acted on until the end of that instruction. It must still be high when sampled (EXEC non-load or WB).
- Exactly one PC_WE pulse per instruction, plus one per interrupt entry.

## Test plan
- Reset release → 1 cycle RST_OUT=1, then MEM_RDEN1=1 in FETCH; INSTRET=0; all other enables 0.
- ADDI (OPCODE 0010011) → EXEC shows REG_WE=1, PC_WE=1; INSTRET becomes 1 the next cycle; then FETCH.
- LW (0000011) → EXEC: MEM_RDEN2=1, PC_WE=0; WB: REG_WE=1, PC_WE=1; INSTRET +1 only after WB.
- SW, then BEQ, then CSRRW (1110011, FUNC3=001) → MEM_WE2=1 / PC_WE-only / CSR_WE=1 with REG_WE=1 respectively. Opcode 0000000 → ILLEGAL=1, PC_WE=1, no writes.
- INTR raised during FETCH of an LW and held → FETCH, EXEC, WB, then INTRPT with INT_TAKEN=1 and PC_WE=1, then FETCH; INSTRET +1 total.
- RST_N pulled low during WB → next cycle INIT, REG_WE=0, INSTRET=0. Preload INSTRET near 0xFFFFFFFF via a long run (or force) → it wraps to 0.
